// File: rtl/weighted_sum_seq.sv
// Sequential weighted-sum combiner: one frame of N signed words arrives
// serially, each word is weighted by its position through a single shared
// adder, and one scaled result per frame is held until downstream takes it.
// The result matches the combinational adder-tree combiner bit for bit.
module weighted_sum_seq #(
  parameter int W         = 28,
  parameter int N         = 8,
  parameter int SHIFT_OUT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic         busy,
  output logic [15:0]  frames_done
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic signed [W-1:0] acc, acc_nxt;
  logic [W-1:0]        out_data_nxt;
  logic                out_valid_nxt;
  logic                err_nxt;
  logic [15:0]         frames_done_nxt;

  logic                beat;
  logic                at_last;
  logic                framing_bad;
  logic signed [W-1:0] term;
  logic signed [W-1:0] sum;

  // Positional weight: earlier words are scaled down harder (floor toward
  // -inf, truncated per term before summation); the final word is negated.
  function automatic logic signed [W-1:0] weight_term(
    input logic signed [W-1:0] y,
    input logic [CNT_W-1:0]    k
  );
    int shamt;
    if (k == LAST_K) begin
      weight_term = -y;
    end else begin
      shamt       = N - 1 - int'(k);
      weight_term = y >>> shamt;
    end
  endfunction

  // Final scaling of the accumulated sum; upper bits fall off, zero fill.
  function automatic logic [W-1:0] scale_out(input logic signed [W-1:0] s);
    scale_out = s << SHIFT_OUT;
  endfunction

  // Handshake and status decode from registered state only.
  always_comb begin
    in_ready    = (state == COLLECT);
    busy        = (cnt != '0) || (state == HOLD);
    beat        = in_valid && (state == COLLECT);
    at_last     = (cnt == LAST_K);
    framing_bad = in_last ^ at_last;
    term        = weight_term($signed(in_data), cnt);
    sum         = (cnt == '0) ? term : acc + term;
  end

  // Next-state and datapath update for the shared accumulator.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    acc_nxt         = acc;
    out_data_nxt    = out_data;
    out_valid_nxt   = out_valid;
    err_nxt         = 1'b0;
    frames_done_nxt = frames_done;
    case (state)
      COLLECT: begin
        if (beat) begin
          if (framing_bad) begin
            // Misframed word: drop it and restart the frame cleanly.
            err_nxt = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
          end else if (at_last) begin
            out_data_nxt  = scale_out(sum);
            out_valid_nxt = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = HOLD;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt   = 1'b0;
          frames_done_nxt = frames_done + 16'd1;
          state_nxt       = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Register stage: all state and outputs; reset overrides every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= '0;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err         <= 1'b0;
      frames_done <= 16'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      err         <= err_nxt;
      frames_done <= frames_done_nxt;
    end
  end

endmodule

// File: tb/tb_weighted_sum_seq.sv
// Self-checking bench for weighted_sum_seq: a frame-level reference model
// predicts every registered output each cycle, and directed frames carry
// hand-computed literal results.
module tb_weighted_sum_seq;

  localparam int W         = 28;
  localparam int N         = 8;
  localparam int SHIFT_OUT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         err;
  logic         busy;
  logic [15:0]  frames_done;

  int n_checks = 0;
  int n_pass   = 0;

  weighted_sum_seq #(.W(W), .N(N), .SHIFT_OUT(SHIFT_OUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Whole-frame result from plain wide integer arithmetic.
  function automatic logic [W-1:0] frame_result(input logic [W-1:0] y[N]);
    longint s = 0;
    longint v;
    for (int k = 0; k < N; k++) begin
      v = longint'($signed(y[k]));
      if (k == N - 1) s = s - v;
      else            s = s + (v >>> (N - 1 - k));
    end
    return W'(s << SHIFT_OUT);
  endfunction

  // Reference model: collects words of a frame, then computes the result.
  logic [W-1:0] m_words[N];
  int           m_pos = 0;
  logic         m_hold = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_out = '0;
  logic [15:0]  m_frames = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_hold = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_out = '0; m_frames = '0;
    end else begin
      m_err = 1'b0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0; m_valid = 1'b0; m_frames = m_frames + 16'd1;
        end
      end else if (in_valid) begin
        if (in_last != (m_pos == N - 1)) begin
          m_err = 1'b1; m_pos = 0;
        end else begin
          m_words[m_pos] = in_data;
          if (m_pos == N - 1) begin
            m_out = frame_result(m_words); m_valid = 1'b1; m_hold = 1'b1; m_pos = 0;
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_out);
    check("err", err, m_err);
    check("in_ready", in_ready, !m_hold);
    check("busy", busy, (m_pos != 0) || m_hold);
    check("frames_done", frames_done, m_frames);
  end

  // Drives n_beats words back to back; in_last on the final one if asked.
  // Returns just after the edge that captured the final word.
  task automatic send_frame(input logic [W-1:0] y[N], input int n_beats, input bit last_on_final);
    for (int i = 0; i < n_beats; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = y[i];
      in_last  = (i == n_beats - 1) && last_on_final;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic after_accept(input logic [15:0] exp_frames);
    @(posedge clk); #1;
    check("accept_frames", frames_done, exp_frames);
    check("accept_ready", in_ready, 1'b1);
  endtask

  logic [W-1:0] ya[N], yb[N], yc[N], yd[N], ye[N], yf[N];

  initial begin
    ya = '{28'd128, 28'd128, 28'd128, 28'd128, 28'd128, 28'd128, 28'd128, 28'd0};
    yb = '{28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd1};
    yc = '{28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'h8000000};
    yd = '{28'hFFFFFFF, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0};
    ye = '{28'h7FFFFFF, 28'h8000000, 28'h1234567, 28'hFEDCBA9,
           28'hFFFFFFB, 28'd3, 28'h4000000, 28'h0ABCDEF};
    yf = '{28'h8000001, 28'h7FFFFFF, 28'h7FFFFFF, 28'h7FFFFFF,
           28'h7FFFFFF, 28'h7FFFFFF, 28'h7FFFFFF, 28'h8000000};

    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 28'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frames_done, 16'd0);
    @(negedge clk); rst = 1'b0;

    send_frame(ya, N, 1'b1);
    check("A_valid", out_valid, 1'b1);
    check("A_data", out_data, 28'h00003F8);
    check("A_err", err, 1'b0);
    after_accept(16'd1);

    send_frame(yb, N, 1'b1);
    check("B_data", out_data, 28'hFFFFFF8);
    after_accept(16'd2);

    send_frame(yc, N, 1'b1);
    check("C_data", out_data, 28'h0000000);
    after_accept(16'd3);

    send_frame(yd, N, 1'b1);
    check("D_floor", out_data, 28'hFFFFFF8);
    after_accept(16'd4);

    // Early in_last on the fifth word.
    send_frame(ya, 5, 1'b1);
    check("early_err", err, 1'b1);
    check("early_noout", out_valid, 1'b0);
    @(posedge clk); #1;
    check("early_err_pulse", err, 1'b0);
    send_frame(ya, N, 1'b1);
    check("recover_data", out_data, 28'h00003F8);
    after_accept(16'd5);

    // Missing in_last on the eighth word.
    send_frame(ya, N, 1'b0);
    check("late_err", err, 1'b1);
    check("late_noout", out_valid, 1'b0);
    check("late_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Backpressure: result held while downstream stalls.
    out_ready = 1'b0;
    send_frame(ya, N, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 28'h00003F8);
      check("hold_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data  = 28'h0123456;
      @(posedge clk); #1;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_valid", out_valid, 1'b0);
    check("hold_release_frames", frames_done, 16'd6);
    check("hold_release_ready", in_ready, 1'b1);

    // Reset in the middle of a frame.
    send_frame(ya, 3, 1'b0);
    check("mid_busy", busy, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_frames", frames_done, 16'd0);
    @(negedge clk); rst = 1'b0;
    send_frame(ya, N, 1'b1);
    check("post_rst_data", out_data, 28'h00003F8);
    after_accept(16'd1);

    // Mixed-value frames with wrap-around, left to the model.
    send_frame(ye, N, 1'b1);
    @(posedge clk); #1;
    send_frame(yf, N, 1'b1);
    @(posedge clk); #1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) ye[k] = W'($urandom);
      send_frame(ye, N, 1'b1);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
